// File: rtl/cdma_despreader.sv
// Walsh-code despreader: correlates the summed chip stream against one code,
// builds DATA_WIDTH-bit words LSB first, and queues them in a 2-entry buffer.
// Optional feature macro: DESPREADER_ZERO_CHECK_EN (adds dout_err word tag).
module cdma_despreader #(
    parameter int DATA_WIDTH     = 8,
    parameter int CODE_WIDTH     = 8,
    parameter int LOG_CODE_WIDTH = 3,
    parameter int SUM_WIDTH      = 4,
    parameter int CODE_NUM       = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  chan_valid,
    input  logic [SUM_WIDTH-1:0]  chan_sum,
    input  logic                  frame_start,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  overflow,
`ifdef DESPREADER_ZERO_CHECK_EN
    output logic                  dout_err,
`endif
    output logic                  sync_err
);
    localparam int AW = SUM_WIDTH + LOG_CODE_WIDTH;
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
`ifdef DESPREADER_ZERO_CHECK_EN
    localparam int EW = DATA_WIDTH + 1;
`else
    localparam int EW = DATA_WIDTH;
`endif
    localparam logic [LOG_CODE_WIDTH-1:0] CODE_BITS = LOG_CODE_WIDTH'(CODE_NUM);
    localparam logic [LOG_CODE_WIDTH-1:0] LAST_CHIP = LOG_CODE_WIDTH'(CODE_WIDTH - 1);
    localparam logic [BW-1:0]             LAST_BIT  = BW'(DATA_WIDTH - 1);

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t                     state_q, state_d;
    logic [LOG_CODE_WIDTH-1:0]  chip_cnt_q, chip_cnt_d;
    logic [BW-1:0]              bit_cnt_q, bit_cnt_d;
    logic signed [AW-1:0]       acc_q, acc_d;
    logic [DATA_WIDTH-1:0]      word_q, word_d;
    logic [EW-1:0]              head_q, head_d, tail_q, tail_d;
    logic                       head_vld_q, head_vld_d, tail_vld_q, tail_vld_d;
    logic                       overflow_q, overflow_d;
    logic                       sync_err_q, sync_err_d;
`ifdef DESPREADER_ZERO_CHECK_EN
    logic                       werr_q, werr_d, werr_base;
`endif

    logic                       start, active, push, pop, dbit;
    logic [LOG_CODE_WIDTH-1:0]  k;
    logic [BW-1:0]              b;
    logic signed [AW-1:0]       sum_ext, term, corr;
    logic [EW-1:0]              push_data;

    always_comb begin
        state_d    = state_q;
        chip_cnt_d = chip_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        acc_d      = acc_q;
        word_d     = word_q;
        push       = 1'b0;
        dbit       = 1'b0;
`ifdef DESPREADER_ZERO_CHECK_EN
        werr_d     = werr_q;
`endif
        // Any qualified frame_start restarts at chip 0 of bit 0.
        start      = chan_valid && frame_start;
        active     = chan_valid && (start || state_q == ACCUM);
        sync_err_d = start && state_q == ACCUM && (chip_cnt_q != '0 || bit_cnt_q != '0);
        k          = start ? '0 : chip_cnt_q;
        b          = start ? '0 : bit_cnt_q;
        sum_ext    = {{LOG_CODE_WIDTH{chan_sum[SUM_WIDTH-1]}}, chan_sum};
        term       = (^(CODE_BITS & k)) ? -sum_ext : sum_ext;
        corr       = ((k == '0) ? '0 : acc_q) + term;
`ifdef DESPREADER_ZERO_CHECK_EN
        werr_base  = start ? 1'b0 : werr_q;
`endif
        if (active) begin
            state_d    = ACCUM;
            acc_d      = corr;
            chip_cnt_d = k + 1'b1;
            bit_cnt_d  = b;
`ifdef DESPREADER_ZERO_CHECK_EN
            werr_d     = werr_base;
`endif
            if (k == LAST_CHIP) begin
                dbit   = !corr[AW-1] && (corr != '0);
                word_d = {dbit, word_q[DATA_WIDTH-1:1]};
`ifdef DESPREADER_ZERO_CHECK_EN
                werr_d = werr_base | (corr == '0);
`endif
                if (b == LAST_BIT) begin
                    push      = 1'b1;
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                end else begin
                    bit_cnt_d = b + 1'b1;
                end
            end
        end
`ifdef DESPREADER_ZERO_CHECK_EN
        push_data = {werr_d, word_d};
`else
        push_data = word_d;
`endif
    end

    // Two-register buffer: the head is the output register, so dout is a flop.
    always_comb begin
        pop        = head_vld_q && dout_ready;
        head_d     = head_q;
        head_vld_d = head_vld_q;
        tail_d     = tail_q;
        tail_vld_d = tail_vld_q;
        overflow_d = overflow_q;
        if (pop) begin
            head_d     = tail_q;
            head_vld_d = tail_vld_q;
            tail_vld_d = 1'b0;
        end
        if (push) begin
            if (!head_vld_d) begin
                head_d     = push_data;
                head_vld_d = 1'b1;
            end else if (!tail_vld_d) begin
                tail_d     = push_data;
                tail_vld_d = 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            chip_cnt_q <= '0;
            bit_cnt_q  <= '0;
            acc_q      <= '0;
            word_q     <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            head_vld_q <= 1'b0;
            tail_vld_q <= 1'b0;
            overflow_q <= 1'b0;
            sync_err_q <= 1'b0;
`ifdef DESPREADER_ZERO_CHECK_EN
            werr_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            chip_cnt_q <= chip_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            acc_q      <= acc_d;
            word_q     <= word_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            head_vld_q <= head_vld_d;
            tail_vld_q <= tail_vld_d;
            overflow_q <= overflow_d;
            sync_err_q <= sync_err_d;
`ifdef DESPREADER_ZERO_CHECK_EN
            werr_q     <= werr_d;
`endif
        end
    end

    assign dout       = head_q[DATA_WIDTH-1:0];
    assign dout_valid = head_vld_q;
    assign overflow   = overflow_q;
    assign sync_err   = sync_err_q;
`ifdef DESPREADER_ZERO_CHECK_EN
    assign dout_err   = head_q[DATA_WIDTH];
`endif

endmodule

// File: tb/tb_cdma_despreader.sv
// Randomized/directed bench for cdma_despreader: a chip-level correlation
// model with a 2-deep queue predicts every output cycle by cycle.
module tb_cdma_despreader;
    localparam int DW = 8, CW = 8, LCW = 3, SW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1, chan_valid = 1'b0, frame_start = 1'b0, dout_ready = 1'b0;
    logic [SW-1:0] chan_sum = '0;
    logic [DW-1:0] dout_a, dout_b;
    logic dv_a, dv_b, ovf_a, ovf_b, se_a, se_b;
`ifdef DESPREADER_ZERO_CHECK_EN
    logic de_a, de_b;
`endif

    cdma_despreader #(.DATA_WIDTH(DW), .CODE_WIDTH(CW), .LOG_CODE_WIDTH(LCW),
                      .SUM_WIDTH(SW), .CODE_NUM(3)) u_a (
        .clk(clk), .rst(rst), .chan_valid(chan_valid), .chan_sum(chan_sum),
        .frame_start(frame_start), .dout(dout_a), .dout_valid(dv_a),
        .dout_ready(dout_ready), .overflow(ovf_a),
`ifdef DESPREADER_ZERO_CHECK_EN
        .dout_err(de_a),
`endif
        .sync_err(se_a));

    cdma_despreader #(.DATA_WIDTH(DW), .CODE_WIDTH(CW), .LOG_CODE_WIDTH(LCW),
                      .SUM_WIDTH(SW), .CODE_NUM(5)) u_b (
        .clk(clk), .rst(rst), .chan_valid(chan_valid), .chan_sum(chan_sum),
        .frame_start(frame_start), .dout(dout_b), .dout_valid(dv_b),
        .dout_ready(1'b1), .overflow(ovf_b),
`ifdef DESPREADER_ZERO_CHECK_EN
        .dout_err(de_b),
`endif
        .sync_err(se_b));

    int checks = 0, errors = 0;
    int chips[$];
    int got[$];
    logic [DW:0] q[$];
    bit collecting = 0, m_ovf = 0, m_sync = 0;
    int rdy_mode = 1, stall_mode = 0;

    function automatic int csign(int code, int k);
        return ($countones(code & k) % 2) ? -1 : 1;
    endfunction

    function automatic int clip(int v);
        if (v > 7) return 7;
        if (v < -8) return -8;
        return v;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Superimpose one user's word onto the pending chip buffer.
    task automatic add_word(int code, logic [7:0] d, int zero_bit);
        if (chips.size() == 0) for (int i = 0; i < DW*CW; i++) chips.push_back(0);
        for (int i = 0; i < DW*CW; i++)
            if (i / CW != zero_bit)
                chips[i] += (d[i/CW] ? 1 : -1) * csign(code, i % CW);
    endtask

    function automatic logic [DW:0] decode();
        logic [DW:0] r = '0;
        for (int b = 0; b < DW; b++) begin
            int corr = 0;
            for (int k = 0; k < CW; k++) corr += got[b*CW+k] * csign(3, k);
            if (corr > 0) r[b] = 1'b1;
            if (corr == 0) r[DW] = 1'b1;
        end
        return r;
    endfunction

    task automatic step(bit v, int s, bit fs);
        bit pop;
        chan_valid  = v;
        chan_sum    = s[SW-1:0];
        frame_start = fs;
        dout_ready  = (rdy_mode == 2) ? 1'($urandom % 2) : 1'(rdy_mode);
        pop = q.size() > 0 && dout_ready;
        @(posedge clk);
        m_sync = 0;
        if (rst) begin
            q.delete(); m_ovf = 0; collecting = 0; got.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (v) begin
                if (fs) begin
                    m_sync = collecting;
                    got.delete();
                    collecting = 1;
                end
                if (collecting) begin
                    got.push_back(s);
                    if (got.size() == DW*CW) begin
                        if (q.size() < 2) q.push_back(decode());
                        else m_ovf = 1;
                        collecting = 0;
                    end
                end
            end
        end
        #1;
        chk("dout_valid", dv_a, q.size() > 0);
        if (q.size() > 0) chk("dout", dout_a, q[0][DW-1:0]);
`ifdef DESPREADER_ZERO_CHECK_EN
        if (q.size() > 0) chk("dout_err", de_a, q[0][DW]);
`endif
        chk("overflow", ovf_a, m_ovf);
        chk("sync_err", se_a, m_sync);
    endtask

    task automatic play(int n);
        for (int i = 0; i < n; i++) begin
            if (stall_mode == 1 || (stall_mode == 2 && $urandom % 4 == 0))
                step(0, $urandom_range(0, 15) - 8, 1'($urandom % 2));
            step(1, clip(chips[i]), i == 0);
        end
        chips.delete();
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(0, 0, 0);
    endtask

    initial begin
        rst = 1; idle(2);
        chk("rst_dout", dout_a, 0);
        chk("rst_valid", dv_a, 0);
        rst = 0; idle(2);

        // single word
        add_word(3, 8'hA5, -1); play(64);
        chk("a5_word", dout_a, 8'hA5);
        chk("a5_valid", dv_a, 1);
        idle(3);

        // two users on the channel
        add_word(3, 8'h3C, -1); add_word(5, 8'hFF, -1); play(64);
        chk("mu_a", dout_a, 8'h3C);
        chk("mu_b_valid", dv_b, 1);
        chk("mu_b", dout_b, 8'hFF);
        idle(3);

        // stall every other cycle
        stall_mode = 1; add_word(3, 8'h5A, -1); play(64); stall_mode = 0;
        chk("stall_word", dout_a, 8'h5A);
        idle(3);

        // overflow with consumer blocked
        rdy_mode = 0;
        add_word(3, 8'h11, -1); play(64);
        add_word(3, 8'h22, -1); play(64);
        add_word(3, 8'h33, -1); play(64);
        chk("ovf_set", ovf_a, 1);
        idle(3);
        chk("ovf_head", dout_a, 8'h11);
        rdy_mode = 1; idle(4);
        chk("ovf_sticky", ovf_a, 1);

        // resync: abort after chip 20, then a clean word
        add_word(3, 8'hEE, -1); play(21);
        add_word(3, 8'h77, -1); play(64);
        chk("resync_word", dout_a, 8'h77);
        idle(3);

        // reset mid-word
        add_word(3, 8'h99, -1); play(30);
        rst = 1; idle(1); rst = 0;
        chk("midrst_valid", dv_a, 0);
        chk("midrst_ovf", ovf_a, 0);
        chk("midrst_sync", se_a, 0);
        idle(70);

        // silent bit 2
        add_word(3, 8'hFF, 2); play(64);
        chk("zero_word", dout_a, 8'hFB);
`ifdef DESPREADER_ZERO_CHECK_EN
        chk("zero_err", de_a, 1);
`endif
        idle(3);

        // randomized traffic with stalls, backpressure and aborts
        rdy_mode = 2; stall_mode = 2;
        for (int w = 0; w < 12; w++) begin
            if ($urandom % 5 == 0) begin
                add_word(3, 8'($urandom), -1); play($urandom_range(2, 60));
            end
            add_word(3, 8'($urandom), ($urandom % 6 == 0) ? $urandom_range(0, 7) : -1);
            play(64);
            if ($urandom % 3 == 0) idle($urandom_range(1, 5));
        end
        rdy_mode = 1; stall_mode = 0; idle(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
